mmu_translate_stage: RTL and testbench

//  Two-stage elastic address-translation pipe in front of the dual-port TLB search block.

---
 rtl/mmu_translate_stage.sv | 172 +++++++++++++++++
 tb/tb_mmu_translate_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_translate_stage.sv
// Two-stage elastic address-translation pipe feeding one TLB search port.
// Stage 1 holds the accepted request and drives the TLB search; stage 2
// captures the translated result and presents it to the consumer.

package mmu_translate_pkg;
  localparam int unsigned TLB_IDX_W = 4;
  localparam int unsigned ASID_W    = 8;

  typedef struct packed {
    logic [18:0]       vpn2;
    logic              is_odd_page;
    logic [ASID_W-1:0] asid;
  } search_request_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [1:0]  cache;
    logic        dirty;
    logic        valid;
  } tlb_entry_t;

  typedef struct packed {
    logic                 found;
    logic [TLB_IDX_W-1:0] index;
    tlb_entry_t           entry;
  } search_result_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_REFILL   = 2'd1,
    EXC_INVALID  = 2'd2,
    EXC_MODIFIED = 2'd3
  } tlb_exc_e;
endpackage

module mmu_translate_stage #(
  parameter int unsigned TLB_IDX_W = 4,
  parameter int unsigned ASID_W    = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_vaddr,
  input  logic                             in_is_store,
  input  logic [ASID_W-1:0]                in_asid,
  output mmu_translate_pkg::search_request_t tlb_req,
  input  mmu_translate_pkg::search_result_t  tlb_resp,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_paddr,
  output logic [31:0]                      out_vaddr,
  output logic                             out_cached,
  output logic [TLB_IDX_W-1:0]             out_tlb_index,
  output logic [1:0]                       out_exc
);

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_vaddr_q;
  logic                 s1_is_store_q;
  logic [ASID_W-1:0]    s1_asid_q;

  // Stage 2 registers (drive out_* directly)
  logic                 s2_valid_q, s2_valid_d;
  logic [31:0]          s2_vaddr_q;
  logic [31:0]          s2_paddr_q;
  logic                 s2_cached_q;
  logic [TLB_IDX_W-1:0] s2_index_q;
  mmu_translate_pkg::tlb_exc_e s2_exc_q;

  // Handshake
  logic s2_free, s1_adv, accept;

  // Translation result computed from stage 1 and the TLB response
  logic [31:0]          lk_paddr;
  logic                 lk_cached;
  logic [TLB_IDX_W-1:0] lk_index;
  mmu_translate_pkg::tlb_exc_e lk_exc;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = (!s1_valid_q || s2_free) && !flush;
  assign accept   = in_valid && in_ready;

  assign tlb_req.vpn2        = s1_vaddr_q[31:13];
  assign tlb_req.is_odd_page = s1_vaddr_q[12];
  assign tlb_req.asid        = s1_asid_q;

  assign out_valid     = s2_valid_q;
  assign out_paddr     = s2_paddr_q;
  assign out_vaddr     = s2_vaddr_q;
  assign out_cached    = s2_cached_q;
  assign out_tlb_index = s2_index_q;
  assign out_exc       = s2_exc_q;

  // Segment decode and TLB exception priority (REFILL > INVALID > MODIFIED)
  always_comb begin
    lk_paddr  = {3'b000, s1_vaddr_q[28:0]};
    lk_cached = 1'b0;
    lk_index  = '0;
    lk_exc    = mmu_translate_pkg::EXC_NONE;
    case (s1_vaddr_q[31:29])
      3'b100: lk_cached = 1'b1;
      3'b101: lk_cached = 1'b0;
      default: begin
        lk_paddr  = {tlb_resp.entry.pfn, s1_vaddr_q[11:0]};
        lk_cached = (tlb_resp.entry.cache == 2'b11);
        if (tlb_resp.found) lk_index = tlb_resp.index;
        if (!tlb_resp.found)
          lk_exc = mmu_translate_pkg::EXC_REFILL;
        else if (!tlb_resp.entry.valid)
          lk_exc = mmu_translate_pkg::EXC_INVALID;
        else if (s1_is_store_q && !tlb_resp.entry.dirty)
          lk_exc = mmu_translate_pkg::EXC_MODIFIED;
      end
    endcase
  end

  // Next-state valid bits; flush wins over any load
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)      s1_valid_d = 1'b1;
      else if (s1_adv) s1_valid_d = 1'b0;
      if (s1_adv)         s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
    end
  end

  // Valid bits and stage 1 request capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s1_vaddr_q    <= '0;
      s1_is_store_q <= 1'b0;
      s1_asid_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_vaddr_q    <= in_vaddr;
        s1_is_store_q <= in_is_store;
        s1_asid_q     <= in_asid;
      end
    end
  end

  // Stage 2 result capture; held while the consumer stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_vaddr_q  <= '0;
      s2_paddr_q  <= '0;
      s2_cached_q <= 1'b0;
      s2_index_q  <= '0;
      s2_exc_q    <= mmu_translate_pkg::EXC_NONE;
    end else if (s1_adv && !flush) begin
      s2_vaddr_q  <= s1_vaddr_q;
      s2_paddr_q  <= lk_paddr;
      s2_cached_q <= lk_cached;
      s2_index_q  <= lk_index;
      s2_exc_q    <= lk_exc;
    end
  end

endmodule

// File: tb/tb_mmu_translate_stage.sv
// Directed bench for mmu_translate_stage with a single-entry TLB model.
module tb_mmu_translate_stage;
  import mmu_translate_pkg::*;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_vaddr = '0;
  logic            in_is_store = 1'b0;
  logic [7:0]      in_asid = '0;
  search_request_t tlb_req;
  search_result_t  tlb_resp;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_paddr;
  logic [31:0]     out_vaddr;
  logic            out_cached;
  logic [3:0]      out_tlb_index;
  logic [1:0]      out_exc;

  int vectors = 0;
  int miscompares = 0;

  // TLB model: entry 5 maps vpn2 e_vpn2; odd page programmable, even page invalid
  logic [18:0] e_vpn2 = 19'h2;
  logic [7:0]  e_asid = 8'd3;
  logic        e_g = 1'b0;
  logic [19:0] e_pfn = 20'h12345;
  logic [1:0]  e_c = 2'b11;
  logic        e_d = 1'b1;
  logic        e_v = 1'b1;
  logic        force_resp = 1'b0;

  mmu_translate_stage #(.TLB_IDX_W(4), .ASID_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr),
    .in_is_store(in_is_store), .in_asid(in_asid),
    .tlb_req(tlb_req), .tlb_resp(tlb_resp),
    .out_valid(out_valid), .out_ready(out_ready), .out_paddr(out_paddr),
    .out_vaddr(out_vaddr), .out_cached(out_cached),
    .out_tlb_index(out_tlb_index), .out_exc(out_exc)
  );

  always #5 clock = ~clock;

  always_comb begin
    tlb_resp = '0;
    if (force_resp) begin
      tlb_resp.found       = 1'b1;
      tlb_resp.index       = 4'hF;
      tlb_resp.entry.pfn   = 20'hFFFFF;
      tlb_resp.entry.cache = 2'b11;
      tlb_resp.entry.dirty = 1'b1;
      tlb_resp.entry.valid = 1'b1;
    end else if (tlb_req.vpn2 == e_vpn2 && (e_g || tlb_req.asid == e_asid)) begin
      tlb_resp.found = 1'b1;
      tlb_resp.index = 4'd5;
      if (tlb_req.is_odd_page) begin
        tlb_resp.entry.pfn   = e_pfn;
        tlb_resp.entry.cache = e_c;
        tlb_resp.entry.dirty = e_d;
        tlb_resp.entry.valid = e_v;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One isolated request through an empty pipe with out_ready=1
  task automatic xlate(input string tag, input logic [31:0] va, input logic st,
                       input logic [7:0] asid, input logic full, input logic [31:0] pa,
                       input logic ca, input logic [3:0] idx, input logic [1:0] exc);
    in_valid = 1'b1; in_vaddr = va; in_is_store = st; in_asid = asid;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_vaddr = 32'hDEAD_BEEF; in_asid = ~asid; in_is_store = ~st;
    #1;
    chk({tag, ".latency"}, 32'(out_valid), 32'd0);
    chk({tag, ".tlb_req"}, 32'({va[31:12], asid}), 32'(tlb_req));
    tick();
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_vaddr"}, out_vaddr, va);
    chk({tag, ".out_exc"}, 32'(out_exc), 32'(exc));
    if (full) begin
      chk({tag, ".out_paddr"}, out_paddr, pa);
      chk({tag, ".out_cached"}, 32'(out_cached), 32'(ca));
      chk({tag, ".out_index"}, 32'(out_tlb_index), 32'(idx));
    end
    tick();
    #1;
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  // Load two kseg0 requests with out_ready=0: S2 holds a, S1 holds b
  task automatic fill2(input string tag, input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b0; in_is_store = 1'b0;
    in_valid = 1'b1; in_vaddr = a;
    tick();
    in_vaddr = b;
    tick();
    in_valid = 1'b0;
    #1;
    chk({tag, ".fill_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".fill_vaddr"}, out_vaddr, a);
  endtask

  logic [31:0] rq [4];
  int idx, acc, n, first, last;
  logic [31:0] expv;

  initial begin
    rq[0] = 32'h8000_0100; rq[1] = 32'h8000_0204;
    rq[2] = 32'h8000_0308; rq[3] = 32'h8000_040C;

    // Reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_paddr", out_paddr, 32'd0);
    chk("rst.out_exc", 32'(out_exc), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // T1/T2 unmapped segments
    xlate("T1", 32'h8000_1234, 1'b1, 8'h00, 1'b1, 32'h0000_1234, 1'b1, 4'd0, 2'd0);
    force_resp = 1'b1;
    xlate("T2", 32'hA000_0010, 1'b0, 8'h00, 1'b1, 32'h0000_0010, 1'b0, 4'd0, 2'd0);
    force_resp = 1'b0;
    xlate("kseg2", 32'hC000_5ABC, 1'b0, 8'd3, 1'b0, 32'h0, 1'b0, 4'd0, 2'd1);

    // T3 mapped hits, ASID miss, global, even page invalid
    xlate("T3hit", 32'h0000_5ABC, 1'b0, 8'd3, 1'b1, 32'h1234_5ABC, 1'b1, 4'd5, 2'd0);
    xlate("T3asid", 32'h0000_5ABC, 1'b0, 8'd4, 1'b0, 32'h0, 1'b0, 4'd0, 2'd1);
    e_g = 1'b1;
    xlate("T3glob", 32'h0000_5ABC, 1'b0, 8'd4, 1'b1, 32'h1234_5ABC, 1'b1, 4'd5, 2'd0);
    e_g = 1'b0;
    xlate("T3even", 32'h0000_4ABC, 1'b0, 8'd3, 1'b0, 32'h0, 1'b0, 4'd0, 2'd2);

    // T4 exception priority
    e_v = 1'b0; e_d = 1'b0;
    xlate("T4inv", 32'h0000_5ABC, 1'b0, 8'd3, 1'b0, 32'h0, 1'b0, 4'd0, 2'd2);
    xlate("T4invst", 32'h0000_5ABC, 1'b1, 8'd3, 1'b0, 32'h0, 1'b0, 4'd0, 2'd2);
    e_v = 1'b1;
    xlate("T4mod", 32'h0000_5ABC, 1'b1, 8'd3, 1'b0, 32'h0, 1'b0, 4'd0, 2'd3);
    xlate("T4ld", 32'h0000_5ABC, 1'b0, 8'd3, 1'b1, 32'h1234_5ABC, 1'b1, 4'd5, 2'd0);
    e_c = 2'b10;
    xlate("T4unc", 32'h0000_5FFF, 1'b0, 8'd3, 1'b1, 32'h1234_5FFF, 1'b0, 4'd5, 2'd0);
    e_c = 2'b11; e_d = 1'b1;

    // T5 backpressure: 5 stalled cycles, 4 offered, 2 accepted
    out_ready = 1'b0; in_is_store = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      in_vaddr = (idx < 4) ? rq[idx] : 32'h0;
      #1;
      if (in_valid && in_ready) begin acc++; idx++; end
      if (c >= 2) begin
        chk("T5.hold_valid", 32'(out_valid), 32'd1);
        chk("T5.hold_vaddr", out_vaddr, rq[0]);
        chk("T5.hold_paddr", out_paddr, 32'h0000_0100);
      end
      tick();
    end
    chk("T5.accepted", 32'(acc), 32'd2);
    out_ready = 1'b1; n = 0; first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      in_vaddr = (idx < 4) ? rq[idx] : 32'h0;
      #1;
      if (out_valid && out_ready) begin
        expv = (n < 4) ? rq[n] : 32'h0;
        chk("T5.order", out_vaddr, expv);
        chk("T5.paddr", out_paddr, {3'b000, expv[28:0]});
        if (n == 0) first = c;
        last = c;
        n++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    chk("T5.count", 32'(n), 32'd4);
    chk("T5.rate", 32'(last - first), 32'd3);
    chk("T5.empty", 32'(out_valid), 32'd0);

    // TLB contents change after lookup: S2 keeps captured result
    out_ready = 1'b0;
    in_valid = 1'b1; in_vaddr = 32'h0000_5ABC; in_asid = 8'd3;
    tick();
    in_valid = 1'b0;
    tick();
    e_pfn = 20'h54321; e_v = 1'b0;
    tick(); tick();
    chk("T7.valid", 32'(out_valid), 32'd1);
    chk("T7.paddr", out_paddr, 32'h1234_5ABC);
    chk("T7.exc", 32'(out_exc), 32'd0);
    out_ready = 1'b1;
    tick();
    e_pfn = 20'h12345; e_v = 1'b1;

    // T6 flush with both stages full and a request offered
    fill2("T6", 32'h8000_0A00, 32'h8000_0B00);
    in_valid = 1'b1; in_vaddr = 32'h8000_0C00; flush = 1'b1;
    #1;
    chk("T6.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("T6.flushed", 32'(out_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("T6.no_accept", 32'(out_valid), 32'd0);
    end

    // Async reset mid-stream
    fill2("RST", 32'h8000_0D00, 32'h8000_0E00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("RST.out_valid", 32'(out_valid), 32'd0);
    chk("RST.out_paddr", out_paddr, 32'd0);
    chk("RST.out_vaddr", out_vaddr, 32'd0);
    chk("RST.out_exc", 32'(out_exc), 32'd0);
    @(negedge clock); reset_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("RST.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("RST.empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
